hazard_halt_ctrl: RTL
=====================

// Module: hazard_halt_ctrl
// PURPOSE
//  Pipeline sequencer for the 5-stage MIPS core: drives PC and IF/ID write
//  enables, IF/ID flush and ID/EX bubble. Detects load-use and branch-operand
//  hazards (branches resolve in ID). On the 0xffffffff stop word in ID, drains
//  EX/MEM/WB, then raises a sticky halt. Counts stall cycles for perf/debug.
// PARAMETERS
//  DRAIN_CYCLES  3   cycles after stop leaves ID before halt_done (EX,MEM,WB)
//  CNT_W         32  width of stall_cycles counter
// PORTS
//  clk            in   1      clock, rising edge
//  rst            in   1      synchronous, active-high reset
//  id_instr       in   32     instruction held in IF/ID; rs=[25:21], rt=[20:16]
//  id_valid       in   1      IF/ID holds a real instruction
//  id_uses_rt     in   1      ID instruction reads rt as a source
//  id_is_branch   in   1      ID instruction is beq/bne (compares in ID)
//  id_taken       in   1      branch/jump in ID redirects PC this cycle
//  ex_mem_read    in   1      ID/EX instruction is a load
//  ex_reg_write   in   1      ID/EX instruction writes a register
//  ex_dst         in   5      ID/EX destination register
//  mem_mem_read   in   1      EX/MEM instruction is a load
//  mem_dst        in   5      EX/MEM destination register
//  pc_write       out  1      PC update enable
//  ifid_write     out  1      IF/ID register write enable
//  ifid_flush     out  1      IF/ID load NOP (0x00000000) on next edge
//  idex_bubble    out  1      ID/EX load all-zero control (bubble) on next edge
//  halt_done      out  1      sticky: pipeline drained after stop word
//  stall_cycles   out  CNT_W  count of hazard-stall cycles since reset
// BEHAVIOUR
//  - Outputs combinational from state and inputs; state, counters registered.
//  - FSM: RUN, DRAIN, HALT. Reset -> RUN, drain_cnt=0, stall_cycles=0.
//  - While rst=1: pc_write=0, ifid_write=0, ifid_flush=1, idex_bubble=1,
//    halt_done=0. Reset mid-DRAIN or in HALT returns to RUN.
//  - id_stop = id_valid & (id_instr==32'hffffffff).
//  - match(r) = (r!=0) & (r==rs | (id_uses_rt & r==rt)).
//  - load_use = id_valid & ex_mem_read & match(ex_dst).
//  - br_haz = id_valid & id_is_branch & ((ex_reg_write & match(ex_dst))
//    | (mem_mem_read & match(mem_dst))).
//  - stall = (load_use | br_haz) & ~id_stop; stop word never raises hazards.
//  - RUN, stall: pc_write=0, ifid_write=0, idex_bubble=1, ifid_flush=0;
//    id_taken ignored this cycle; stall_cycles += 1 (wraps at 2^CNT_W).
//  - RUN, ~stall, id_taken: pc_write=1, ifid_write=1, ifid_flush=1.
//  - RUN, id_stop: pc_write=0, ifid_write=0, idex_bubble=1 (stop word never
//    enters EX); next state DRAIN, drain_cnt<=DRAIN_CYCLES-1.
//  - RUN otherwise: pc_write=1, ifid_write=1, flush=0, bubble=0.
//  - DRAIN: pc_write=0, ifid_write=0, idex_bubble=1; drain_cnt decrements;
//    at drain_cnt==0 -> HALT. Inputs other than rst ignored; no stall count.
//  - HALT: as DRAIN plus halt_done=1; remains until rst.
//  - Stop word to halt_done: DRAIN_CYCLES+1 edges after stop seen in ID.
//  - Stall and id_stop never both active; stall has precedence over id_taken.
// TESTING
//  1 lw $t0 in EX (ex_dst=8), add using $t0 in ID -> one cycle pc_write=0,
//    ifid_write=0, idex_bubble=1; stall_cycles 0->1; next cycle RUN normal.
//  2 ex_dst=0 with load, ID reads $0 -> no stall; stall_cycles stays 0.
//  3 beq rs=9 in ID, lw $9 in EX -> stall 2 cycles (EX hazard, then MEM
//    hazard); stall_cycles=2; then id_taken=1 -> ifid_flush=1, pc_write=1.
//  4 0xffffffff in ID with ex_mem_read=1, ex_dst=31 -> no stall; halt_done=1
//    exactly 4 edges later (DRAIN_CYCLES=3); pc_write stays 0 throughout.
//  5 rst pulsed during DRAIN -> state RUN, halt_done=0, stall_cycles=0 next cycle.
//  6 id_stop, id_valid=0 -> ignored; RUN continues, pc_write=1.

Source files
------------

// File: rtl/hazard_halt_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_halt_ctrl
//   Pipeline sequencer for the 5-stage MIPS core. Generates the PC and IF/ID
//   write enables, the IF/ID flush and the ID/EX bubble. Detects load-use and
//   branch-operand hazards (branches resolve in ID). When the 0xffffffff stop
//   word reaches ID the front end freezes, EX/MEM/WB are allowed to drain, and
//   a sticky halt_done is raised. Hazard stall cycles are counted for perf and
//   debug.
//
// Parameters
//   DRAIN_CYCLES  cycles after the stop word leaves ID before halt_done (>= 1)
//   CNT_W         width of the stall_cycles counter
//
// Ports
//   clk, rst        clock (rising edge), synchronous active-high reset
//   id_instr        instruction held in IF/ID (rs=[25:21], rt=[20:16])
//   id_valid        IF/ID holds a real instruction
//   id_uses_rt      ID instruction reads rt as a source
//   id_is_branch    ID instruction is beq/bne (operands compared in ID)
//   id_taken        branch/jump in ID redirects the PC this cycle
//   ex_mem_read     ID/EX instruction is a load
//   ex_reg_write    ID/EX instruction writes a register
//   ex_dst          ID/EX destination register
//   mem_mem_read    EX/MEM instruction is a load
//   mem_dst         EX/MEM destination register
//   pc_write        PC update enable
//   ifid_write      IF/ID write enable
//   ifid_flush      IF/ID loads a NOP on the next edge
//   idex_bubble     ID/EX loads all-zero control on the next edge
//   halt_done       sticky: pipeline drained after the stop word
//   stall_cycles    hazard-stall cycles since reset (wraps)
// -----------------------------------------------------------------------------
module hazard_halt_ctrl #(
  parameter int unsigned DRAIN_CYCLES = 3,
  parameter int unsigned CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      id_instr,
  input  logic             id_valid,
  input  logic             id_uses_rt,
  input  logic             id_is_branch,
  input  logic             id_taken,
  input  logic             ex_mem_read,
  input  logic             ex_reg_write,
  input  logic [4:0]       ex_dst,
  input  logic             mem_mem_read,
  input  logic [4:0]       mem_dst,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             halt_done,
  output logic [CNT_W-1:0] stall_cycles
);

  typedef enum logic [1:0] {RUN, DRAIN, HALT} state_t;

  localparam int unsigned    DCW        = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DCW-1:0] DRAIN_LOAD = DCW'(DRAIN_CYCLES - 1);

  state_t         state;
  logic [DCW-1:0] drain_cnt;

  logic [4:0] rs;
  logic [4:0] rt;
  logic       id_stop;
  logic       load_use;
  logic       br_haz;
  logic       stall;

  assign rs = id_instr[25:21];
  assign rt = id_instr[20:16];

  // A producer register matches the ID sources; $0 is hard-wired and never
  // creates a dependency.
  function automatic logic reg_match(input logic [4:0] r, input logic [4:0] src_rs,
                                     input logic [4:0] src_rt, input logic uses_rt);
    return (r != 5'd0) && ((r == src_rs) || (uses_rt && (r == src_rt)));
  endfunction

  assign id_stop  = id_valid && (id_instr == 32'hffff_ffff);
  assign load_use = id_valid && ex_mem_read && reg_match(ex_dst, rs, rt, id_uses_rt);
  // Branches compare in ID, so any ALU result still in EX and any load still
  // in MEM is not yet available to them.
  assign br_haz   = id_valid && id_is_branch &&
                    ((ex_reg_write && reg_match(ex_dst, rs, rt, id_uses_rt)) ||
                     (mem_mem_read && reg_match(mem_dst, rs, rt, id_uses_rt)));
  // The stop word decodes as rs=rt=31, so it must be excluded from hazards.
  assign stall    = (load_use || br_haz) && !id_stop;

  // NOTE: every output gets a default before the case so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    pc_write    = 1'b0;
    ifid_write  = 1'b0;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b1;
    halt_done   = 1'b0;
    if (rst) begin
      ifid_flush = 1'b1;
    end else begin
      unique case (state)
        RUN: begin
          if (stall || id_stop) begin
            // Front end frozen; id_taken is ignored while stalled.
            idex_bubble = 1'b1;
          end else begin
            pc_write    = 1'b1;
            ifid_write  = 1'b1;
            ifid_flush  = id_taken;
            idex_bubble = 1'b0;
          end
        end
        DRAIN: ;
        HALT:  halt_done = 1'b1;
        default: ;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= RUN;
      drain_cnt    <= '0;
      stall_cycles <= '0;
    end else begin
      unique case (state)
        RUN: begin
          if (stall) begin
            stall_cycles <= stall_cycles + 1'b1;
          end else if (id_stop) begin
            state     <= DRAIN;
            drain_cnt <= DRAIN_LOAD;
          end
        end
        DRAIN: begin
          if (drain_cnt == '0) state <= HALT;
          else                 drain_cnt <= drain_cnt - 1'b1;
        end
        HALT:    state <= HALT;
        default: state <= RUN;
      endcase
    end
  end

endmodule
